ex_mc: RTL and testbench
========================

Name: ex_mc

Overview:
- Parametrised, registered execute stage for the in-order integer pipeline; successor to the single-op combinational execute block.
- Single-cycle logic, shift and arithmetic ops, plus an iterative unsigned multiply/divide unit that stalls the pipeline and writes HI/LO.
- Sits between the ID/EX pipeline register and MEM; all outputs are registered (the EX/MEM register is absorbed).

Parameters:
- DATA_W, 32, operand/result width; power of two, >=8.
- REG_ADDR_W, 5, destination register address width.
- ALUOP_W, 8, aluop_i width.
- ALUSEL_W, 3, alusel_i width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- valid_i  in  1  instruction present in EX this cycle.
- flush_i  in  1  kill the current instruction and abort any mul/div.
- aluop_i  in  ALUOP_W  operation code.
- alusel_i  in  ALUSEL_W  result class.
- reg1_i  in  DATA_W  operand A.
- reg2_i  in  DATA_W  operand B.
- wd_i  in  REG_ADDR_W  destination register.
- wreg_i  in  1  GPR write request.
- valid_o  out  1  registered result valid.
- wd_o  out  REG_ADDR_W  registered destination.
- wreg_o  out  1  registered GPR write enable.
- wdata_o  out  DATA_W  registered GPR result.
- whilo_o  out  1  registered HI/LO write enable.
- hi_o  out  DATA_W  registered HI result.
- lo_o  out  DATA_W  registered LO result.
- stallreq_o  out  1  combinational stall request to the pipeline controller.

Behaviour:
- Opcodes (aluop_i):
  - AND 0x24, OR 0x25, XOR 0x26, NOR 0x27.
  - SLL 0x7C, SRL 0x02, SRA 0x03.
  - ADDU 0x21, SUBU 0x23, SLT 0x2A.
  - MULTU 0x19, DIVU 0x1B.
  - Any other opcode gives result 0.
- Result class (alusel_i): NOP 3'b000, LOGIC 3'b001, SHIFT 3'b010, ARITH 3'b100. Any other value selects result 0.
- Shifts: shift amount is reg1_i[log2(DATA_W)-1:0], applied to reg2_i. SRA replicates reg2_i[DATA_W-1].
- ADDU/SUBU: modulo 2^DATA_W, no overflow detection.
- SLT: signed compare; result is 1 or 0, zero-extended.
- Reset (rst=0, asynchronous): all outputs 0; FSM to IDLE; mul/div counter and working registers cleared.
- Single-cycle ops: result appears on the outputs at the clk edge after presentation (latency 1).
  - valid_o <= valid_i & ~flush_i.
  - wreg_o <= wreg_i & valid_i & ~flush_i.
  - whilo_o <= 0.
- Mul/div FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY when valid_i & (MULTU|DIVU) & ~flush_i. Operands are latched and the counter is set to 0.
  - BUSY: one iteration per cycle for DATA_W cycles. MULTU uses shift-add. DIVU uses restoring division. After DATA_W iterations -> DONE.
  - DONE: outputs register captures valid_o=1, whilo_o=1, wreg_o=0, wdata_o=0. MULTU: {hi_o,lo_o} = 2*DATA_W-bit product. DIVU: lo_o = quotient, hi_o = remainder. FSM -> IDLE.
  - DIVU with reg2_i==0: IDLE -> DONE directly. Result is lo_o = all ones, hi_o = reg1_i.
- stallreq_o = valid_i & (MULTU|DIVU) & (state != DONE).
  - Normal mul/div presented at cycle c: stalls cycles c..c+DATA_W; low in DONE at c+DATA_W+1; result registered at the end of that cycle.
  - Upstream holds all inputs stable while stallreq_o=1. The block ignores input changes while in BUSY.
- While stallreq_o=1, the outputs register loads a bubble: valid_o=0, wreg_o=0, whilo_o=0. wdata_o, hi_o and lo_o hold their previous values.
- flush_i=1 in any state:
  - FSM -> IDLE and the mul/div is abandoned.
  - Next edge: valid_o=0, wreg_o=0, whilo_o=0.
  - stallreq_o is low in that cycle (flush overrides).
- A new mul/div may be accepted in the cycle after DONE (back-to-back; IDLE stall cycle applies again).
- Reset mid-operation clears everything immediately. No partial result is ever emitted.

Test Plan:
- Reset then OR: release rst; valid_i=1, aluop 0x25, alusel 001, reg1=0x0F0F0000, reg2=0x000000FF, wd=5, wreg=1. Next edge: valid_o=1, wd_o=5, wreg_o=1, wdata_o=0x0F0F00FF, whilo_o=0.
- Shift/compare:
  - SRA with reg1=4, reg2=0x80000010 -> wdata_o=0xF8000001.
  - SLT with reg1=0xFFFFFFFF, reg2=1 -> wdata_o=1.
  - SUBU 0-1 -> 0xFFFFFFFF.
- MULTU reg1=0xFFFFFFFF, reg2=2 (DATA_W=32): stallreq_o high 33 cycles then low 1 cycle. Then valid_o=1, whilo_o=1, hi_o=1, lo_o=0xFFFFFFFE, wreg_o=0. valid_o=0 during all stall cycles.
- DIVU 100/7 -> lo_o=14, hi_o=2 after the same timing. DIVU 100/0 -> single stall cycle, then lo_o=0xFFFFFFFF, hi_o=100.
- Flush at BUSY cycle 10 of a MULTU: stallreq_o drops that cycle; no whilo_o pulse. A following OR completes normally with latency 1.
- Drive rst low mid-DIVU: all outputs 0 asynchronously (before next clk). After release, DIVU 9/3 -> lo_o=3, hi_o=0.

Source files
------------

// File: rtl/ex_mc_if.sv
// Bundles the execute-stage inputs from ID/EX and the registered results toward MEM.
interface ex_mc_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 8,
    parameter int ALUSEL_W   = 3
) ();
    logic                  valid_i;
    logic                  flush_i;
    logic [ALUOP_W-1:0]    aluop_i;
    logic [ALUSEL_W-1:0]   alusel_i;
    logic [DATA_W-1:0]     reg1_i;
    logic [DATA_W-1:0]     reg2_i;
    logic [REG_ADDR_W-1:0] wd_i;
    logic                  wreg_i;
    logic                  valid_o;
    logic [REG_ADDR_W-1:0] wd_o;
    logic                  wreg_o;
    logic [DATA_W-1:0]     wdata_o;
    logic                  whilo_o;
    logic [DATA_W-1:0]     hi_o;
    logic [DATA_W-1:0]     lo_o;
    logic                  stallreq_o;

    // Upstream side: presents instructions, observes results and stall
    modport master (
        output valid_i, flush_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
        input  valid_o, wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );

    // Execute stage side
    modport slave (
        input  valid_i, flush_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
        output valid_o, wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );
endinterface

// File: rtl/ex_mc.sv
// Registered execute stage: single-cycle logic/shift/arith ops plus an
// iterative unsigned multiply/divide unit that stalls the pipeline and
// writes HI/LO. The EX/MEM register is absorbed into this block.
module ex_mc #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 8,
    parameter int ALUSEL_W   = 3
) (
    input logic    clk,
    input logic    rst,
    ex_mc_if.slave bus
);
    localparam int SHAMT_W = $clog2(DATA_W);
    localparam int CNT_W   = $clog2(DATA_W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ALUOP_W-1:0] OP_AND   = ALUOP_W'(8'h24);
    localparam logic [ALUOP_W-1:0] OP_OR    = ALUOP_W'(8'h25);
    localparam logic [ALUOP_W-1:0] OP_XOR   = ALUOP_W'(8'h26);
    localparam logic [ALUOP_W-1:0] OP_NOR   = ALUOP_W'(8'h27);
    localparam logic [ALUOP_W-1:0] OP_SLL   = ALUOP_W'(8'h7C);
    localparam logic [ALUOP_W-1:0] OP_SRL   = ALUOP_W'(8'h02);
    localparam logic [ALUOP_W-1:0] OP_SRA   = ALUOP_W'(8'h03);
    localparam logic [ALUOP_W-1:0] OP_ADDU  = ALUOP_W'(8'h21);
    localparam logic [ALUOP_W-1:0] OP_SUBU  = ALUOP_W'(8'h23);
    localparam logic [ALUOP_W-1:0] OP_SLT   = ALUOP_W'(8'h2A);
    localparam logic [ALUOP_W-1:0] OP_MULTU = ALUOP_W'(8'h19);
    localparam logic [ALUOP_W-1:0] OP_DIVU  = ALUOP_W'(8'h1B);

    localparam logic [ALUSEL_W-1:0] SEL_LOGIC = ALUSEL_W'(3'b001);
    localparam logic [ALUSEL_W-1:0] SEL_SHIFT = ALUSEL_W'(3'b010);
    localparam logic [ALUSEL_W-1:0] SEL_ARITH = ALUSEL_W'(3'b100);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              is_div;
    logic [DATA_W-1:0] work_hi;
    logic [DATA_W-1:0] work_lo;
    logic [DATA_W-1:0] operand_b;

    logic              is_mul_op;
    logic              is_div_op;
    logic              is_md_op;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0] logic_res;
    logic [DATA_W-1:0] shift_res;
    logic [DATA_W-1:0] arith_res;
    logic [DATA_W-1:0] result;
    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W:0]   div_diff;

    assign is_mul_op = (bus.aluop_i == OP_MULTU);
    assign is_div_op = (bus.aluop_i == OP_DIVU);
    assign is_md_op  = is_mul_op | is_div_op;
    assign shamt     = bus.reg1_i[SHAMT_W-1:0];

    // Hold the pipeline until the mul/div reaches DONE; a flush always releases it
    assign bus.stallreq_o = bus.valid_i & is_md_op & (state != S_DONE) & ~bus.flush_i;

    // Single-cycle result: compute each class, then pick by alusel
    always_comb begin
        logic_res = '0;
        shift_res = '0;
        arith_res = '0;
        result    = '0;
        case (bus.aluop_i)
            OP_AND:  logic_res = bus.reg1_i & bus.reg2_i;
            OP_OR:   logic_res = bus.reg1_i | bus.reg2_i;
            OP_XOR:  logic_res = bus.reg1_i ^ bus.reg2_i;
            OP_NOR:  logic_res = ~(bus.reg1_i | bus.reg2_i);
            default: logic_res = '0;
        endcase
        case (bus.aluop_i)
            OP_SLL:  shift_res = bus.reg2_i << shamt;
            OP_SRL:  shift_res = bus.reg2_i >> shamt;
            OP_SRA:  shift_res = DATA_W'($signed(bus.reg2_i) >>> shamt);
            default: shift_res = '0;
        endcase
        case (bus.aluop_i)
            OP_ADDU: arith_res = bus.reg1_i + bus.reg2_i;
            OP_SUBU: arith_res = bus.reg1_i - bus.reg2_i;
            OP_SLT:  arith_res = {{(DATA_W-1){1'b0}},
                                  ($signed(bus.reg1_i) < $signed(bus.reg2_i))};
            default: arith_res = '0;
        endcase
        case (bus.alusel_i)
            SEL_LOGIC: result = logic_res;
            SEL_SHIFT: result = shift_res;
            SEL_ARITH: result = arith_res;
            default:   result = '0;
        endcase
    end

    // One mul/div iteration: shift-add for multiply, restoring step for divide.
    // HI/LO working pair holds {partial product, multiplier} or {remainder, quotient}.
    always_comb begin
        mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, operand_b} : '0);
        div_shift = {work_hi, work_lo[DATA_W-1]};
        div_diff  = div_shift - {1'b0, operand_b};
    end

    // Mul/div sequencer: accept in IDLE, iterate DATA_W times in BUSY, present in DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            is_div    <= 1'b0;
            work_hi   <= '0;
            work_lo   <= '0;
            operand_b <= '0;
        end else if (bus.flush_i) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.valid_i && is_md_op) begin
                        is_div <= is_div_op;
                        cnt    <= '0;
                        if (is_div_op && (bus.reg2_i == '0)) begin
                            work_hi <= bus.reg1_i;
                            work_lo <= '1;
                            state   <= S_DONE;
                        end else begin
                            work_hi   <= '0;
                            work_lo   <= bus.reg1_i;
                            operand_b <= bus.reg2_i;
                            state     <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (is_div) begin
                        if (!div_diff[DATA_W]) begin
                            work_hi <= div_diff[DATA_W-1:0];
                            work_lo <= {work_lo[DATA_W-2:0], 1'b1};
                        end else begin
                            work_hi <= div_shift[DATA_W-1:0];
                            work_lo <= {work_lo[DATA_W-2:0], 1'b0};
                        end
                    end else begin
                        {work_hi, work_lo} <= {mul_sum, work_lo[DATA_W-1:1]};
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DATA_W-1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // EX/MEM output register: flush kills, stall inserts a bubble, DONE emits HI/LO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.valid_o <= 1'b0;
            bus.wd_o    <= '0;
            bus.wreg_o  <= 1'b0;
            bus.wdata_o <= '0;
            bus.whilo_o <= 1'b0;
            bus.hi_o    <= '0;
            bus.lo_o    <= '0;
        end else if (bus.flush_i || bus.stallreq_o) begin
            bus.valid_o <= 1'b0;
            bus.wreg_o  <= 1'b0;
            bus.whilo_o <= 1'b0;
        end else if (state == S_DONE) begin
            bus.valid_o <= 1'b1;
            bus.wd_o    <= bus.wd_i;
            bus.wreg_o  <= 1'b0;
            bus.wdata_o <= '0;
            bus.whilo_o <= 1'b1;
            bus.hi_o    <= work_hi;
            bus.lo_o    <= work_lo;
        end else begin
            bus.valid_o <= bus.valid_i;
            bus.wd_o    <= bus.wd_i;
            bus.wreg_o  <= bus.wreg_i & bus.valid_i;
            bus.wdata_o <= result;
            bus.whilo_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ex_mc.sv
// Directed self-checking bench for ex_mc with DATA_W=32.
module tb_ex_mc;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    ex_mc_if bus ();

    ex_mc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time guard against a hung run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wd, input logic wr);
        bus.valid_i  = 1'b1;
        bus.aluop_i  = op;
        bus.alusel_i = sel;
        bus.reg1_i   = a;
        bus.reg2_i   = b;
        bus.wd_i     = wd;
        bus.wreg_i   = wr;
        #1;
    endtask

    // Presents a mul/div, counts stall cycles, watches bubbles, then clocks the DONE capture
    task automatic run_md(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int stalls, output logic bubble_ok);
        stalls    = 0;
        bubble_ok = 1'b1;
        drive(op, 3'b100, a, b, 5'd9, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (!bus.stallreq_o) break;
            stalls++;
            step();
            if (bus.valid_o !== 1'b0 || bus.whilo_o !== 1'b0 || bus.wreg_o !== 1'b0)
                bubble_ok = 1'b0;
        end
        step();
    endtask

    task automatic test_reset();
        rst           = 1'b0;
        bus.valid_i   = 1'b0;
        bus.flush_i   = 1'b0;
        bus.aluop_i   = '0;
        bus.alusel_i  = '0;
        bus.reg1_i    = '0;
        bus.reg2_i    = '0;
        bus.wd_i      = '0;
        bus.wreg_i    = 1'b0;
        #2;
        n_tests++;
        if ({bus.valid_o, bus.wd_o, bus.wreg_o, bus.wdata_o, bus.whilo_o, bus.hi_o, bus.lo_o} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got valid=%b wdata=%h hi=%h lo=%h, expected all zero",
                     bus.valid_o, bus.wdata_o, bus.hi_o, bus.lo_o);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_logic_or();
        drive(8'h25, 3'b001, 32'h0F0F_0000, 32'h0000_00FF, 5'd5, 1'b1);
        step();
        n_tests++;
        if (bus.valid_o !== 1'b1 || bus.wd_o !== 5'd5 || bus.wreg_o !== 1'b1 || bus.whilo_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL or_ctrl: got valid=%b wd=%0d wreg=%b whilo=%b, expected 1 5 1 0",
                     bus.valid_o, bus.wd_o, bus.wreg_o, bus.whilo_o);
        end
        n_tests++;
        if (bus.wdata_o !== 32'h0F0F_00FF) begin
            n_fail++;
            $display("[TB] FAIL or_data: got %h expected 0f0f00ff", bus.wdata_o);
        end
    endtask

    task automatic test_shift_compare();
        logic [7:0]  ops  [10] = '{8'h03, 8'h2A, 8'h23, 8'h7C, 8'h02, 8'h27, 8'h21, 8'h7C, 8'h25, 8'h26};
        logic [2:0]  sels [10] = '{3'b010, 3'b100, 3'b100, 3'b010, 3'b010, 3'b001, 3'b100, 3'b001, 3'b011, 3'b001};
        logic [31:0] as   [10] = '{32'd4, 32'hFFFF_FFFF, 32'd0, 32'd4, 32'd4, 32'd0, 32'hFFFF_FFFF,
                                   32'd1, 32'hFFFF_FFFF, 32'hFF00_FF00};
        logic [31:0] bs   [10] = '{32'h8000_0010, 32'd1, 32'd1, 32'd1, 32'h8000_0010, 32'd0, 32'd2,
                                   32'd1, 32'd1, 32'h0FF0_0FF0};
        logic [31:0] exps [10] = '{32'hF800_0001, 32'd1, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0800_0001,
                                   32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'hF0F0_F0F0};
        for (int i = 0; i < 10; i++) begin
            drive(ops[i], sels[i], as[i], bs[i], 5'(i + 1), 1'b1);
            step();
            n_tests++;
            if (bus.wdata_o !== exps[i] || bus.valid_o !== 1'b1 || bus.wd_o !== 5'(i + 1)) begin
                n_fail++;
                $display("[TB] FAIL vec%0d op=%h: got wdata=%h valid=%b wd=%0d, expected %h 1 %0d",
                         i, ops[i], bus.wdata_o, bus.valid_o, bus.wd_o, exps[i], i + 1);
            end
        end
        drive(8'h21, 3'b100, 32'd3, 32'd4, 5'd2, 1'b0);
        step();
        n_tests++;
        if (bus.wreg_o !== 1'b0 || bus.wdata_o !== 32'd7) begin
            n_fail++;
            $display("[TB] FAIL addu_nowreg: got wreg=%b wdata=%h, expected 0 00000007", bus.wreg_o, bus.wdata_o);
        end
    endtask

    task automatic test_multu();
        int   stalls;
        logic bubble_ok;
        run_md(8'h19, 32'hFFFF_FFFF, 32'd2, stalls, bubble_ok);
        n_tests++;
        if (stalls !== 33) begin
            n_fail++;
            $display("[TB] FAIL multu_stalls: got %0d expected 33", stalls);
        end
        n_tests++;
        if (bubble_ok !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL multu_bubble: got bubble_ok=%b expected 1", bubble_ok);
        end
        n_tests++;
        if (bus.valid_o !== 1'b1 || bus.whilo_o !== 1'b1 || bus.wreg_o !== 1'b0 ||
            bus.hi_o !== 32'd1 || bus.lo_o !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("[TB] FAIL multu_result: got valid=%b whilo=%b wreg=%b hi=%h lo=%h, expected 1 1 0 00000001 fffffffe",
                     bus.valid_o, bus.whilo_o, bus.wreg_o, bus.hi_o, bus.lo_o);
        end
    endtask

    // Issued in the cycle straight after the previous DONE
    task automatic test_back_to_back();
        int   stalls;
        logic bubble_ok;
        run_md(8'h1B, 32'd100, 32'd7, stalls, bubble_ok);
        n_tests++;
        if (stalls !== 33 || bubble_ok !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL divu_stalls: got stalls=%0d bubble_ok=%b, expected 33 1", stalls, bubble_ok);
        end
        n_tests++;
        if (bus.valid_o !== 1'b1 || bus.whilo_o !== 1'b1 || bus.hi_o !== 32'd2 || bus.lo_o !== 32'd14) begin
            n_fail++;
            $display("[TB] FAIL divu_result: got valid=%b whilo=%b hi=%h lo=%h, expected 1 1 00000002 0000000e",
                     bus.valid_o, bus.whilo_o, bus.hi_o, bus.lo_o);
        end
    endtask

    task automatic test_divu_zero();
        int   stalls;
        logic bubble_ok;
        run_md(8'h1B, 32'd100, 32'd0, stalls, bubble_ok);
        n_tests++;
        if (stalls !== 1) begin
            n_fail++;
            $display("[TB] FAIL divzero_stalls: got %0d expected 1", stalls);
        end
        n_tests++;
        if (bus.valid_o !== 1'b1 || bus.whilo_o !== 1'b1 || bus.hi_o !== 32'd100 || bus.lo_o !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("[TB] FAIL divzero_result: got valid=%b whilo=%b hi=%h lo=%h, expected 1 1 00000064 ffffffff",
                     bus.valid_o, bus.whilo_o, bus.hi_o, bus.lo_o);
        end
        bus.valid_i = 1'b0;
        step();
    endtask

    task automatic test_flush();
        logic saw_whilo;
        drive(8'h19, 3'b100, 32'd12345, 32'd678, 5'd3, 1'b0);
        for (int i = 0; i < 10; i++) step();
        bus.flush_i = 1'b1;
        #1;
        n_tests++;
        if (bus.stallreq_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL flush_stall: got stallreq=%b expected 0", bus.stallreq_o);
        end
        step();
        n_tests++;
        if (bus.valid_o !== 1'b0 || bus.wreg_o !== 1'b0 || bus.whilo_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL flush_kill: got valid=%b wreg=%b whilo=%b, expected 0 0 0",
                     bus.valid_o, bus.wreg_o, bus.whilo_o);
        end
        bus.flush_i = 1'b0;
        drive(8'h25, 3'b001, 32'h1234_0000, 32'h0000_5678, 5'd7, 1'b1);
        n_tests++;
        if (bus.stallreq_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL post_flush_stall: got stallreq=%b expected 0", bus.stallreq_o);
        end
        step();
        n_tests++;
        if (bus.valid_o !== 1'b1 || bus.wreg_o !== 1'b1 || bus.wd_o !== 5'd7 ||
            bus.wdata_o !== 32'h1234_5678 || bus.whilo_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL post_flush_or: got valid=%b wreg=%b wd=%0d wdata=%h whilo=%b, expected 1 1 7 12345678 0",
                     bus.valid_o, bus.wreg_o, bus.wd_o, bus.wdata_o, bus.whilo_o);
        end
        bus.valid_i = 1'b0;
        saw_whilo   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.whilo_o !== 1'b0) saw_whilo = 1'b1;
        end
        n_tests++;
        if (saw_whilo !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL flush_no_whilo: got whilo pulse=%b expected 0", saw_whilo);
        end
    endtask

    task automatic test_reset_mid();
        int   stalls;
        logic bubble_ok;
        drive(8'h1B, 3'b100, 32'd100, 32'd7, 5'd4, 1'b0);
        for (int i = 0; i < 5; i++) step();
        rst = 1'b0;
        #1;
        n_tests++;
        if ({bus.valid_o, bus.wd_o, bus.wreg_o, bus.wdata_o, bus.whilo_o, bus.hi_o, bus.lo_o} !== '0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got valid=%b wdata=%h hi=%h lo=%h, expected all zero",
                     bus.valid_o, bus.wdata_o, bus.hi_o, bus.lo_o);
        end
        bus.valid_i = 1'b0;
        step();
        rst = 1'b1;
        step();
        run_md(8'h1B, 32'd9, 32'd3, stalls, bubble_ok);
        n_tests++;
        if (stalls !== 33 || bus.valid_o !== 1'b1 || bus.whilo_o !== 1'b1 ||
            bus.lo_o !== 32'd3 || bus.hi_o !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL divu_after_reset: got stalls=%0d valid=%b whilo=%b hi=%h lo=%h, expected 33 1 1 00000000 00000003",
                     stalls, bus.valid_o, bus.whilo_o, bus.hi_o, bus.lo_o);
        end
        bus.valid_i = 1'b0;
        step();
    endtask

    // Scenario sequence
    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_logic_or();
        test_shift_compare();
        test_multu();
        test_back_to_back();
        test_divu_zero();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
